// File: rtl/mono_filter_pkg.sv
// Shared definitions for the monochrome filter pipeline: mode encodings,
// default Rec.709 luma weights, the sync/blank bundle and the mode decoder.
package mono_filter_pkg;

    localparam logic [2:0] MODE_COLOUR = 3'd0;
    localparam logic [2:0] MODE_GREEN  = 3'd1;
    localparam logic [2:0] MODE_AMBER  = 3'd2;
    localparam logic [2:0] MODE_WHITE  = 3'd3;
    localparam logic [2:0] MODE_TINT   = 3'd4;

    // Rec.709 weights as 8-bit fractions (0.2126, 0.7152, 0.0722 of 256)
    localparam int LUMA_KR = 54;
    localparam int LUMA_KG = 183;
    localparam int LUMA_KB = 18;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } timing_t;

    function automatic logic [2:0] decode_mode(input logic [2:0] mode);
        logic [2:0] res;
        case (mode)
            MODE_GREEN, MODE_AMBER, MODE_WHITE, MODE_TINT: res = mode;
            default:                                       res = MODE_COLOUR;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mono_filter_pipe_luma_calc.sv
// Two-stage RGB -> luma: registered weighted products, then rounded and
// saturated sum. Usable wherever a CW-bit luma with 2-cycle latency is needed.
module luma_calc
    import mono_filter_pkg::*;
#(
    parameter int CW = 6,
    parameter int KR = LUMA_KR,
    parameter int KG = LUMA_KG,
    parameter int KB = LUMA_KB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] r_i,
    input  logic [CW-1:0] g_i,
    input  logic [CW-1:0] b_i,
    output logic [CW-1:0] y_o
);

    localparam logic [CW+7:0] KR_W  = (CW+8)'(KR);
    localparam logic [CW+7:0] KG_W  = (CW+8)'(KG);
    localparam logic [CW+7:0] KB_W  = (CW+8)'(KB);
    localparam logic [CW+1:0] Y_MAX = (CW+2)'((2**CW) - 1);

    logic [CW+7:0] pr_q, pg_q, pb_q;
    logic [CW+9:0] sum_s;
    logic [CW+1:0] y_raw_s;
    logic [CW-1:0] y_d;

    // Round-to-nearest, then clamp in case custom weights sum above 256
    always_comb begin
        sum_s   = (CW+10)'(pr_q) + (CW+10)'(pg_q) + (CW+10)'(pb_q) + (CW+10)'(9'd128);
        y_raw_s = (CW+2)'(sum_s >> 4'd8);
        if (y_raw_s > Y_MAX) begin
            y_d = {CW{1'b1}};
        end else begin
            y_d = y_raw_s[CW-1:0];
        end
    end

    // Stage 1 products and stage 2 luma register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr_q <= '0;
            pg_q <= '0;
            pb_q <= '0;
            y_o  <= '0;
        end else begin
            pr_q <= KR_W * (CW+8)'(r_i);
            pg_q <= KG_W * (CW+8)'(g_i);
            pb_q <= KB_W * (CW+8)'(b_i);
            y_o  <= y_d;
        end
    end

endmodule

// File: rtl/mono_filter_pipe.sv
// Video filter between the generator and the VGA pins: colour, green, amber,
// white or tinted luma, with syncs delayed to match the 3-cycle pixel path.
module mono_filter_pipe
    import mono_filter_pkg::*;
#(
    parameter int   CW         = 6,
    parameter int   KR         = LUMA_KR,
    parameter int   KG         = LUMA_KG,
    parameter int   KB         = LUMA_KB,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter logic FRAME_SYNC = 1'b1
) (
    input  logic          clk_vga,
    input  logic          rst,
    input  logic [2:0]    mode_req,
    input  logic [CW-1:0] tint_r,
    input  logic [CW-1:0] tint_g,
    input  logic [CW-1:0] tint_b,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          blank_in,
    output logic [CW-1:0] r_out,
    output logic [CW-1:0] g_out,
    output logic [CW-1:0] b_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          blank_out,
    output logic [2:0]    mode_active,
    output logic          mode_pending
);

    localparam timing_t TIMING_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, blank: 1'b1};

    logic [2:0]      req_dec_s, mode_sel_s, mode_active_q;
    logic            vs_edge_s, capture_s, vs_prev_q;
    logic [3*CW-1:0] tint_q, tint_sel_s;
    logic [3*CW-1:0] s1_pix_q, s2_pix_q, s1_tint_q, s2_tint_q;
    logic [2:0]      s1_mode_q, s2_mode_q;
    timing_t         s1_tim_q, s2_tim_q;
    logic [CW-1:0]   y_s, r_d, g_d, b_d;
    logic [2*CW-1:0] tpr_s, tpg_s, tpb_s;

    // On a frame edge the incoming pixel already takes the newly requested mode/tint
    always_comb begin
        req_dec_s = decode_mode(mode_req);
        vs_edge_s = (vsync_in == VS_POL) && (vs_prev_q != VS_POL);
        if (FRAME_SYNC && vs_edge_s) begin
            mode_sel_s = req_dec_s;
            tint_sel_s = {tint_r, tint_g, tint_b};
        end else begin
            mode_sel_s = mode_active_q;
            tint_sel_s = tint_q;
        end
        if (FRAME_SYNC) begin
            capture_s = vs_edge_s;
        end else begin
            capture_s = 1'b1;
        end
    end

    // Mode/tint latch and vsync edge history
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            vs_prev_q     <= ~VS_POL;
            mode_active_q <= MODE_COLOUR;
            tint_q        <= '0;
        end else begin
            vs_prev_q <= vsync_in;
            if (capture_s) begin
                mode_active_q <= req_dec_s;
                tint_q        <= {tint_r, tint_g, tint_b};
            end
        end
    end

    assign mode_active  = mode_active_q;
    assign mode_pending = (req_dec_s != mode_active_q);

    luma_calc #(.CW(CW), .KR(KR), .KG(KG), .KB(KB)) u_luma (
        .clk (clk_vga),
        .rst (rst),
        .r_i (r_in),
        .g_i (g_in),
        .b_i (b_in),
        .y_o (y_s)
    );

    // Stage 3 mode mux; tint of full scale reproduces y exactly
    always_comb begin
        tpr_s = (2*CW)'(y_s) * ((2*CW)'(s2_tint_q[3*CW-1 -: CW]) + (2*CW)'(1'b1));
        tpg_s = (2*CW)'(y_s) * ((2*CW)'(s2_tint_q[2*CW-1 -: CW]) + (2*CW)'(1'b1));
        tpb_s = (2*CW)'(y_s) * ((2*CW)'(s2_tint_q[CW-1:0])       + (2*CW)'(1'b1));
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (s2_tim_q.blank) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end else begin
            case (s2_mode_q)
                MODE_GREEN: g_d = y_s;
                MODE_AMBER: begin
                    r_d = y_s;
                    g_d = {1'b0, y_s[CW-1:1]};
                end
                MODE_WHITE: begin
                    r_d = y_s;
                    g_d = y_s;
                    b_d = y_s;
                end
                MODE_TINT: begin
                    r_d = CW'(tpr_s >> CW);
                    g_d = CW'(tpg_s >> CW);
                    b_d = CW'(tpb_s >> CW);
                end
                default: {r_d, g_d, b_d} = s2_pix_q;
            endcase
        end
    end

    // Pixel/timing/mode delay line alongside the luma stages, plus output registers
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            s1_pix_q  <= '0;
            s1_tim_q  <= TIMING_IDLE;
            s1_mode_q <= MODE_COLOUR;
            s1_tint_q <= '0;
            s2_pix_q  <= '0;
            s2_tim_q  <= TIMING_IDLE;
            s2_mode_q <= MODE_COLOUR;
            s2_tint_q <= '0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            hsync_out <= ~HS_POL;
            vsync_out <= ~VS_POL;
            blank_out <= 1'b1;
        end else begin
            s1_pix_q  <= {r_in, g_in, b_in};
            s1_tim_q  <= '{hs: hsync_in, vs: vsync_in, blank: blank_in};
            s1_mode_q <= mode_sel_s;
            s1_tint_q <= tint_sel_s;
            s2_pix_q  <= s1_pix_q;
            s2_tim_q  <= s1_tim_q;
            s2_mode_q <= s1_mode_q;
            s2_tint_q <= s1_tint_q;
            r_out     <= r_d;
            g_out     <= g_d;
            b_out     <= b_d;
            hsync_out <= s2_tim_q.hs;
            vsync_out <= s2_tim_q.vs;
            blank_out <= s2_tim_q.blank;
        end
    end

endmodule

// File: doc/mono_filter_pipe.md
Name: mono_filter_pipe

Overview:
- Pipelined, parametrised successor to the top-level monochrome switcher.
- Sits between the video generator output and the VGA pins.
- Converts RGB to luma using fixed-point Rec.709 weights; emits colour, green, amber, white or programmable-tint video.
- Registers all outputs and delays sync/blank to match the data latency.
- Mode and tint changes take effect only at a frame boundary, so mid-frame switching cannot tear.

Parameters:
- CW, 6, bits per colour channel.
- KR, 54, red weight, 8-bit fraction (0.2126*256).
- KG, 183, green weight, 8-bit fraction.
- KB, 18, blue weight, 8-bit fraction.
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.
- FRAME_SYNC, 1. 1 = apply mode/tint at vsync assertion; 0 = apply on the next clock.

Ports:
- clk_vga  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- mode_req  in  3  requested mode: 0 colour, 1 green, 2 amber, 3 white, 4 tint; 5-7 behave as 0.
- tint_r, tint_g, tint_b  in  CW each  tint colour for mode 4.
- r_in, g_in, b_in  in  CW each  source pixel.
- hsync_in, vsync_in, blank_in  in  1 each  source timing.
- r_out, g_out, b_out  out  CW each  filtered pixel.
- hsync_out, vsync_out, blank_out  out  1 each  timing, delayed to match the pixel.
- mode_active  out  3  mode currently applied to new pixels.
- mode_pending  out  1  high while mode_req != mode_active.

Behaviour:
- Reset (async, any time including mid-frame):
  - RGB outputs = 0; blank_out = 1.
  - hsync_out = !HS_POL; vsync_out = !VS_POL (inactive levels).
  - mode_active = 0; latched tint = 0; all pipeline valid/sync stages flushed to the same inactive values.
  - vsync edge detector's previous-sample register = !VS_POL, so the first asserting sample after reset counts as an edge.
- Latency: fixed 3 clk_vga cycles, input to output, for pixel, hsync, vsync and blank alike. There is no backpressure; one pixel is accepted per clock.
- Stage 1 registers:
  - products pr = KR*r_in, pg = KG*g_in, pb = KB*b_in, each CW+8 bits;
  - syncs, blank, and the mode/tint selected for this pixel.
- Stage 2:
  - y = (pr+pg+pb+128) >> 8, with the sum computed in CW+10 bits;
  - y saturates to 2^CW-1;
  - the input pixel is carried alongside for colour mode.
- Stage 3, mode mux, registered to the outputs:
  - colour: (r, g, b) passthrough.
  - green: (0, y, 0).
  - amber: (y, y>>1, 0).
  - white: (y, y, y).
  - tint: c_out = (y*(tint_c+1)) >> CW per channel; tint 2^CW-1 gives y, tint 0 gives y>>CW = 0.
  - blank in this stage forces RGB = 0 in every mode.
- Mode/tint latch, FRAME_SYNC=1:
  - An edge is a cycle where vsync_in == VS_POL and the previous sample != VS_POL.
  - On that cycle, mode_req and tint_* are captured into mode_active/tint registers.
  - The pixel presented on that same cycle already uses the new values, because the mode travels with the pixel through the pipeline. Pixels already in flight keep their mode.
  - If mode_req changes on the edge cycle itself, the value present on that cycle is the one taken.
  - With no vsync edge, mode_active holds indefinitely.
- Mode/tint latch, FRAME_SYNC=0: capture every cycle; the new mode is seen by the pixel entering the following cycle.
- mode_pending is combinational from mode_req vs mode_active (decoded: 5-7 compare as 0). It drops the cycle after the capture.
- Tint changes alone never raise mode_pending.

Decomposition:
- Package mono_filter_pkg holds:
  - mode encodings: MODE_COLOUR, MODE_GREEN, MODE_AMBER, MODE_WHITE, MODE_TINT;
  - default weight constants KR/KG/KB;
  - a decode function that maps 5-7 to MODE_COLOUR.
- One sub-module, luma_calc (stages 1-2: multiply, sum, round, saturate; parametrised CW/KR/KG/KB). It is reusable by a future scaler/OSD path.
- The top level holds the mode latch, sync delay line and stage-3 mux.

Test Plan:
- Reset: assert rst mid-line with active video -> same cycle RGB=0, blank_out=1, hsync_out=vsync_out=1, mode_active=0; release -> first input emerges after exactly 3 clocks.
- Colour: mode 0 applied, in (10,20,30) -> out (10,20,30) at cycle+3; hsync/vsync/blank toggles arrive in the same cycle as their pixel.
- Luma modes, FRAME_SYNC=0:
  - white, in (63,63,63) -> (63,63,63);
  - green, in (63,0,0) -> (0,13,0);
  - amber, in (0,63,0) -> (45,22,0);
  - invalid mode 6 -> colour passthrough.
- Tint: mode 4, tint (63,31,0), in (63,63,63) -> (63,31,0); tint (0,0,0) -> (0,0,0).
- Frame deferral, FRAME_SYNC=1: mode_req 0->3 mid-frame -> mode_pending=1 and output stays colour. On vsync_in falling, that pixel exits white 3 cycles later; mode_active=3 and mode_pending=0 the next cycle. Changing mode_req exactly on the edge cycle captures the new value.
- Blank: blank_in=1 with in (63,63,63), any mode -> (0,0,0) with blank_out=1 at cycle+3.
